// File: rtl/boot_loader_ctrl_pkg.sv
// Shared types and constants for the UART boot loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package boot_pkg;

  // Bytes per length field and per instruction word.
  localparam int WORD_BYTES = 4;

  localparam logic [7:0] ACK_DEFAULT = 8'hAA;
  localparam logic [7:0] NAK_DEFAULT = 8'hEE;

  typedef enum logic [2:0] {
    RECV_LEN,
    RECV_WORD,
    WRITE,
    ACK,
    NAK,
    WAIT_TX,
    RUN,
    ERROR
  } boot_state_t;

endpackage

// File: rtl/boot_loader_ctrl_byte_assembler.sv
// Big-endian 4-byte shift register with wrapping byte counter.
// Latency: word_next/done are combinational off the byte being shifted in.
// Backpressure: none; every shift_en cycle consumes din.
module byte_assembler
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        shift_en,
  input  logic [7:0]  din,
  output logic [31:0] word_next,
  output logic [1:0]  byte_cnt,
  output logic        done
);

  logic [31:0] shift_reg;

  // First byte of a group ends up in [31:24] after four shifts.
  assign word_next = {shift_reg[23:0], din};
  assign done      = shift_en && (byte_cnt == 2'(WORD_BYTES - 1));

  // Shift in the byte and advance the counter; the counter wraps to 0
  // after the fourth byte so the next group starts cleanly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_reg <= '0;
      byte_cnt  <= '0;
    end else if (shift_en) begin
      shift_reg <= word_next;
      byte_cnt  <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/boot_loader_ctrl.sv
// Boot loader: receives a length-prefixed program over UART, writes it to imem, ACK/NAKs, releases the core.
// Latency: imem_we one cycle after the 4th byte of each word; tx_start one cycle after ACK/NAK with tx idle.
// Backpressure: none on rx (bytes arrive as pulses); tx_start is held off while tx_busy is high.
module boot_loader_ctrl
  import boot_pkg::*;
#(
  parameter int         ADDR_W      = 14,
  parameter int         TIMEOUT_CYC = 2_000_000,
  parameter logic [7:0] ACK_BYTE    = ACK_DEFAULT,
  parameter logic [7:0] NAK_BYTE    = NAK_DEFAULT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_ferr,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              cpu_run,
  output logic              load_err
);

  localparam int              TO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [32:0]     CAPACITY = 33'(1) << ADDR_W;

  boot_state_t     state;
  logic [ADDR_W:0] word_cnt;
  logic [ADDR_W:0] num_words;
  logic [TO_W-1:0] idle_cnt;
  logic            ack_sel;
  logic            busy_seen;

  logic            rx_active;
  logic            shift_en;
  logic [31:0]     word_next;
  logic [1:0]      byte_cnt;
  logic            byte_done;
  logic            idle_run;
  logic            timeout;

  // WRITE still accepts bytes so a back-to-back byte starts the next word.
  assign rx_active = (state == RECV_LEN) || (state == RECV_WORD) || (state == WRITE);
  // A framing error on the same cycle discards the byte.
  assign shift_en  = rx_valid && !rx_ferr && rx_active;

  byte_assembler u_asm (
    .clk       (clk),
    .rstn      (rstn),
    .shift_en  (shift_en),
    .din       (rx_data),
    .word_next (word_next),
    .byte_cnt  (byte_cnt),
    .done      (byte_done)
  );

  // Idle time only matters once a frame has started.
  assign idle_run = (state == RECV_WORD) || ((state == RECV_LEN) && (byte_cnt != 2'd0));
  assign timeout  = idle_run && !rx_valid && (idle_cnt == TO_LAST);

  // Idle counter: cleared by every byte and whenever no frame is in progress.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_cnt <= '0;
    end else if (rx_valid || !idle_run) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TO_ONE;
    end
  end

  // Main sequencer with registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= RECV_LEN;
      word_cnt   <= '0;
      num_words  <= '0;
      ack_sel    <= 1'b0;
      busy_seen  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      cpu_run    <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      imem_we  <= 1'b0;
      tx_start <= 1'b0;
      case (state)
        RECV_LEN: begin
          if (rx_ferr || timeout) begin
            state <= NAK;
          end else if (byte_done) begin
            if ({1'b0, word_next} > CAPACITY) begin
              state <= NAK;
            end else if (word_next == 32'd0) begin
              state <= ACK;
            end else begin
              num_words <= word_next[ADDR_W:0];
              state     <= RECV_WORD;
            end
          end
        end
        RECV_WORD: begin
          if (rx_ferr || timeout) begin
            state <= NAK;
          end else if (byte_done) begin
            imem_we    <= 1'b1;
            imem_addr  <= word_cnt[ADDR_W-1:0];
            imem_wdata <= word_next;
            state      <= WRITE;
          end
        end
        WRITE: begin
          word_cnt <= word_cnt + CNT_ONE;
          if ((word_cnt + CNT_ONE) == num_words) begin
            state <= ACK;
          end else begin
            state <= RECV_WORD;
          end
        end
        ACK: begin
          if (!tx_busy) begin
            tx_start  <= 1'b1;
            tx_data   <= ACK_BYTE;
            ack_sel   <= 1'b1;
            busy_seen <= 1'b0;
            state     <= WAIT_TX;
          end
        end
        NAK: begin
          if (!tx_busy) begin
            tx_start  <= 1'b1;
            tx_data   <= NAK_BYTE;
            ack_sel   <= 1'b0;
            busy_seen <= 1'b0;
            state     <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (tx_busy) begin
            busy_seen <= 1'b1;
          end else if (busy_seen) begin
            if (ack_sel) begin
              cpu_run <= 1'b1;
              state   <= RUN;
            end else begin
              load_err <= 1'b1;
              state    <= ERROR;
            end
          end
        end
        RUN:     state <= RUN;
        ERROR:   state <= ERROR;
        default: state <= ERROR;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl: vector table, directed corner sequences, randomized loads.
// Latency: n/a.
// Backpressure: a simple transmitter model raises tx_busy after each tx_start.
module tb_boot_loader_ctrl;

  localparam int ADDR_W = 4;
  localparam int TO     = 300;
  localparam int CAP    = 1 << ADDR_W;
  localparam int TX_LEN = 20;

  logic              clk = 1'b0;
  logic              rstn;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ferr;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              cpu_run;
  logic              load_err;
  logic              busy_m;
  logic              hold_busy;

  assign tx_busy = busy_m | hold_busy;

  boot_loader_ctrl #(
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ferr    (rx_ferr),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .cpu_run    (cpu_run),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  typedef logic [ADDR_W+31:0] wr_t;  // {addr, data}

  typedef struct {
    logic [31:0] len;
    int          nsend;
    int          ferr_at;
    logic [7:0]  etx;
    logic        erun;
    logic        eerr;
    int          ewr;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  wr_t         wr_q[$];
  wr_t         exp_q[$];
  logic [7:0]  stim_q[$];
  logic [31:0] words_q[$];
  int          ferr_idx;
  int          tx_base;
  int          tx_cnt    = 0;
  logic [7:0]  tx_last   = 8'h00;
  int          viol      = 0;
  int          lat_viol  = 0;
  logic        prev_ok   = 1'b0;
  time         tx_time   = 0;
  time         last_rx_time;
  vec_t        vecs[9];

  // Observe DUT outputs on the falling edge.
  always @(negedge clk) begin
    prev_ok <= rx_valid && !rx_ferr;
    if (imem_we) begin
      wr_q.push_back({imem_addr, imem_wdata});
      if (!prev_ok) lat_viol <= lat_viol + 1;
    end
    if (tx_start) begin
      tx_cnt  <= tx_cnt + 1;
      tx_last <= tx_data;
      tx_time <= $time;
      if (tx_busy) viol <= viol + 1;
    end
  end

  // Transmitter model: busy starts the cycle after tx_start and lasts TX_LEN cycles.
  initial begin
    busy_m = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        @(posedge clk); #1;
        busy_m = 1'b1;
        repeat (TX_LEN) @(posedge clk);
        #1;
        busy_m = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_q();
    wr_q.delete();
    exp_q.delete();
    stim_q.delete();
    words_q.delete();
    ferr_idx = -1;
    tx_base  = tx_cnt;
  endtask

  task automatic do_reset();
    rx_valid  = 1'b0;
    rx_ferr   = 1'b0;
    rx_data   = 8'h00;
    hold_busy = 1'b0;
    rstn      = 1'b0;
    cycles(3);
    rstn = 1'b1;
    cycles(2);
  endtask

  task automatic start_load();
    do_reset();
    clear_q();
  endtask

  task automatic build_frame(input logic [31:0] len, input int nsend);
    logic [31:0] w;
    for (int b = 3; b >= 0; b--) stim_q.push_back(len[8*b +: 8]);
    for (int i = 0; i < nsend; i++) begin
      w = $urandom;
      words_q.push_back(w);
      for (int b = 3; b >= 0; b--) stim_q.push_back(w[8*b +: 8]);
    end
  endtask

  task automatic exp_from_words(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({ADDR_W'(i), words_q[i]});
  endtask

  // Called while sitting 1 time unit after a rising edge.
  task automatic drive_byte(input logic [7:0] b, input logic f, input int gap);
    rx_data      = b;
    rx_valid     = 1'b1;
    rx_ferr      = f;
    last_rx_time = $time;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input int gap_max);
    int   gap;
    logic f;
    for (int i = 0; i < stim_q.size(); i++) begin
      f   = (i == ferr_idx);
      gap = ($urandom_range(0, 19) == 0) ? 200 : $urandom_range(0, gap_max);
      drive_byte(stim_q[i], f, gap);
      if (f) break;
    end
  endtask

  // Reference: parse the byte stream as the protocol defines it.
  task automatic model(output logic [7:0] etx, output logic erun, output logic eerr);
    int          avail;
    int          full;
    logic [31:0] n;
    avail = (ferr_idx >= 0 && ferr_idx < stim_q.size()) ? ferr_idx : stim_q.size();
    exp_q.delete();
    etx = 8'hEE; erun = 1'b0; eerr = 1'b1;
    if (avail >= 4) begin
      n = {stim_q[0], stim_q[1], stim_q[2], stim_q[3]};
      if (n <= 32'(CAP)) begin
        full = (avail - 4) / 4;
        if (full > int'(n)) full = int'(n);
        for (int w = 0; w < full; w++)
          exp_q.push_back({ADDR_W'(w), stim_q[4+4*w], stim_q[5+4*w], stim_q[6+4*w], stim_q[7+4*w]});
        if (full == int'(n)) begin
          etx = 8'hAA; erun = 1'b1; eerr = 1'b0;
        end
      end
    end
  endtask

  task automatic check_load(input string tag, input logic [7:0] etx, input logic erun, input logic eerr);
    int k;
    k = 0;
    while (!(cpu_run || load_err) && k < 20000) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_done"}, 64'(k < 20000), 64'(1));
    cycles(3);
    chk({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
      chk({tag, "_wr"}, 64'(wr_q[i]), 64'(exp_q[i]));
    chk({tag, "_txn"}, 64'(tx_cnt - tx_base), 64'(1));
    chk({tag, "_txd"}, 64'(tx_last), 64'(etx));
    chk({tag, "_run"}, 64'(cpu_run), 64'(erun));
    chk({tag, "_err"}, 64'(load_err), 64'(eerr));
    chk({tag, "_txbusy"}, 64'(viol), 64'(0));
    chk({tag, "_wlat"}, 64'(lat_viol), 64'(0));
  endtask

  initial begin
    logic [7:0] etx;
    logic       erun;
    logic       eerr;
    longint     dcyc;
    logic [31:0] rlen;

    vecs[0] = '{32'd0,         0,  -1, 8'hAA, 1'b1, 1'b0, 0};
    vecs[1] = '{32'd16,        16, -1, 8'hAA, 1'b1, 1'b0, 16};
    vecs[2] = '{32'd17,        0,  -1, 8'hEE, 1'b0, 1'b1, 0};
    vecs[3] = '{32'h8000_0000, 0,  -1, 8'hEE, 1'b0, 1'b1, 0};
    vecs[4] = '{32'd3,         3,   5, 8'hEE, 1'b0, 1'b1, 0};
    vecs[5] = '{32'd2,         2,  11, 8'hEE, 1'b0, 1'b1, 1};
    vecs[6] = '{32'd2,         1,  -1, 8'hEE, 1'b0, 1'b1, 1};
    vecs[7] = '{32'd1,         1,   0, 8'hEE, 1'b0, 1'b1, 0};
    vecs[8] = '{32'd5,         5,  -1, 8'hAA, 1'b1, 1'b0, 5};

    // Reset state.
    rx_valid = 1'b0; rx_ferr = 1'b0; rx_data = 8'h00; hold_busy = 1'b0;
    rstn = 1'b0;
    cycles(2);
    chk("rst_we",   64'(imem_we),    64'(0));
    chk("rst_addr", 64'(imem_addr),  64'(0));
    chk("rst_wd",   64'(imem_wdata), 64'(0));
    chk("rst_txd",  64'(tx_data),    64'(0));
    chk("rst_txs",  64'(tx_start),   64'(0));
    chk("rst_run",  64'(cpu_run),    64'(0));
    chk("rst_err",  64'(load_err),   64'(0));

    // Directed: two-word load, then traffic in RUN is ignored.
    start_load();
    words_q.push_back(32'h1234_5678);
    words_q.push_back(32'h9ABC_DEF0);
    stim_q = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_frame(3);
    exp_from_words(2);
    check_load("two_word", 8'hAA, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) drive_byte(8'(i), i[0], 1);
    cycles(3);
    chk("run_ignore_wr",  64'(wr_q.size()), 64'(2));
    chk("run_ignore_run", 64'(cpu_run),     64'(1));
    chk("run_ignore_err", 64'(load_err),    64'(0));
    // Asynchronous drop of cpu_run.
    #3 rstn = 1'b0;
    #1 chk("async_run_drop", 64'(cpu_run), 64'(0));
    cycles(2);

    // Table-driven vectors.
    for (int v = 0; v < 9; v++) begin
      start_load();
      build_frame(vecs[v].len, vecs[v].nsend);
      ferr_idx = vecs[v].ferr_at;
      send_frame(8);
      exp_from_words(vecs[v].ewr);
      check_load($sformatf("vec%0d", v), vecs[v].etx, vecs[v].erun, vecs[v].eerr);
    end

    // Timeout after a partial word, and its timing.
    start_load();
    stim_q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22};
    for (int i = 0; i < stim_q.size(); i++) drive_byte(stim_q[i], 1'b0, 2);
    check_load("timeout", 8'hEE, 1'b0, 1'b1);
    dcyc = longint'((tx_time - last_rx_time) / 10);
    n_cmp++;
    if (dcyc < TO || dcyc > TO + 4) begin
      n_bad++;
      $display("FAIL timeout_delay: got %0d cycles expected %0d..%0d", dcyc, TO, TO + 4);
    end

    // tx held busy at end of load.
    start_load();
    hold_busy = 1'b1;
    build_frame(32'd1, 1);
    send_frame(4);
    cycles(5000);
    chk("hold_no_tx",  64'(tx_cnt - tx_base), 64'(0));
    chk("hold_no_run", 64'(cpu_run),          64'(0));
    hold_busy = 1'b0;
    exp_from_words(1);
    check_load("hold", 8'hAA, 1'b1, 1'b0);

    // Reset in the middle of a three-word load, then a fresh one-word load.
    start_load();
    build_frame(32'd3, 3);
    for (int i = 0; i < 12; i++) drive_byte(stim_q[i], 1'b0, 2);
    cycles(2);
    chk("pre_rst_wr", 64'(wr_q.size()), 64'(2));
    #3 rstn = 1'b0;
    #1;
    chk("mid_rst_we",  64'(imem_we),  64'(0));
    chk("mid_rst_txs", 64'(tx_start), 64'(0));
    chk("mid_rst_run", 64'(cpu_run),  64'(0));
    cycles(2);
    rstn = 1'b1;
    cycles(2);
    clear_q();
    build_frame(32'd1, 1);
    send_frame(4);
    exp_from_words(1);
    check_load("reload", 8'hAA, 1'b1, 1'b0);

    // Randomized loads against the reference parser.
    for (int r = 0; r < 30; r++) begin
      start_load();
      if ($urandom_range(0, 9) < 7) rlen = 32'($urandom_range(0, CAP));
      else if ($urandom_range(0, 1) == 0) rlen = 32'($urandom_range(CAP + 1, 100));
      else rlen = $urandom | 32'h0001_0000;
      build_frame(rlen, (rlen <= 32'(CAP)) ? int'(rlen) : 0);
      if ($urandom_range(0, 4) == 0) ferr_idx = $urandom_range(0, stim_q.size() - 1);
      if ($urandom_range(0, 6) == 0) begin
        int keep;
        keep = $urandom_range(1, stim_q.size() - 1);
        while (stim_q.size() > keep) void'(stim_q.pop_back());
      end
      send_frame(12);
      model(etx, erun, eerr);
      check_load($sformatf("rnd%0d", r), etx, erun, eerr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
